// File: rtl/iter_divider.sv
// ============================================================================
// Module   : iter_divider
// Purpose  : Multi-cycle restoring divider: quotient, remainder and
//            divide-by-zero flag over WIDTH iteration cycles, start/busy/done.
//            Signed support is compiled in with `define ITER_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_orig;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_div_zero = (divisor == '0);
  assign busy       = (r_state != S_IDLE);

`ifdef ITER_DIVIDER_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_neg = signed_op & dividend[WIDTH-1];
  assign w_dvs_neg = signed_op & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end

  // Truncating division: remainder follows the dividend's sign.
  assign w_q_fix = r_neg_q ? -r_q : r_q;
  assign w_r_fix = r_neg_r ? -r_a : r_a;
`else
  logic w_unused_signed_op;

  assign w_unused_signed_op = signed_op;
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_fix   = r_q;
  assign w_r_fix   = r_a;
`endif

  // A restored after each step is below M, so WIDTH bits of storage suffice;
  // only the shifted value needs the extra bit for the trial subtraction.
  assign w_shift = {r_a, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};

  always_comb begin
    w_a_next = w_diff[WIDTH-1:0];
    w_q_next = {r_q[WIDTH-2:0], 1'b1};
    if (w_diff[WIDTH]) begin
      w_a_next = w_shift[WIDTH-1:0];
      w_q_next = {r_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_div_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == c_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_orig      <= '0;
      r_dbz       <= 1'b0;
      r_cnt       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= '0;
            r_q    <= w_dvd_mag;
            r_m    <= w_dvs_mag;
            r_orig <= dividend;
            r_dbz  <= w_div_zero;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= r_dbz;
          quotient    <= r_dbz ? '1 : w_q_fix;
          remainder   <= r_dbz ? r_orig : w_r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// Module   : tb_iter_divider
// Purpose  : Directed scoreboard bench for iter_divider (WIDTH=32 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, sop32, busy32, done32, dbz32;
  logic [31:0] dvd32, dvs32, q32, r32;
  logic        start8, sop8, busy8, done8, dbz8;
  logic [7:0]  dvd8, dvs8, q8, r8;

  iter_divider #(.WIDTH(32)) u_dut32 (
    .clock(clk), .reset(rst), .start(start32), .signed_op(sop32),
    .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
  );

  iter_divider #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst), .start(start8), .signed_op(sop8),
    .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   t_acc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit w8, input logic sop, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int elat, input string tag);
    exp_t e;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.tag = tag;
      sb.push_back(e);
    end
    if (w8) begin
      start8 = 1'b1; sop8 = sop; dvd8 = a[7:0]; dvs8 = b[7:0];
    end else begin
      start32 = 1'b1; sop32 = sop; dvd32 = a; dvs32 = b;
    end
    tick();
    start8  = 1'b0;
    start32 = 1'b0;
    t_acc   = cyc;
    check({tag, "/busy_at_accept"}, w8 ? busy8 : busy32, 1);
    check({tag, "/done_low_at_accept"}, w8 ? done8 : done32, 0);
  endtask

  task automatic wait_done(input bit w8);
    exp_t e;
    int   n;
    n = 0;
    while (!(w8 ? done8 : done32) && n < 200) begin
      tick();
      n++;
    end
    check("scoreboard_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "/done"}, w8 ? done8 : done32, 1);
      check({e.tag, "/latency"}, cyc - t_acc, e.lat);
      check({e.tag, "/busy_in_done"}, w8 ? busy8 : busy32, 0);
      check({e.tag, "/quotient"}, w8 ? {24'h0, q8} : q32, e.q);
      check({e.tag, "/remainder"}, w8 ? {24'h0, r8} : r32, e.r);
      check({e.tag, "/div_by_zero"}, w8 ? dbz8 : dbz32, e.dbz);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1;
    start32 = 1'b0; sop32 = 1'b0; dvd32 = '0; dvs32 = '0;
    start8  = 1'b0; sop8  = 1'b0; dvd8  = '0; dvs8  = '0;
    repeat (3) tick();
    check("reset/busy", busy32, 0);
    check("reset/done", done32, 0);
    check("reset/quotient", q32, 0);
    check("reset/remainder", r32, 0);
    check("reset/div_by_zero", dbz32, 0);
    rst = 1'b0;
    tick();

    // Unsigned basic case, with one-cycle done width checked on the next cycle.
    start_op(0, 0, 100, 7, 1, 14, 2, 0, 33, "u100_7");
    wait_done(0);
    tick();
    check("u100_7/done_one_cycle", done32, 0);

`ifdef ITER_DIVIDER_SIGNED_EN
    start_op(0, 1, 32'hFFFF_FFF9, 2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33, "s_m7_2");
    wait_done(0);
    start_op(0, 1, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 1, 0, 33, "s_7_m2");
    wait_done(0);
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0, 33, "s_min_m1");
    wait_done(0);
`else
    start_op(0, 1, 32'hFFFF_FFF9, 2, 1, 32'h7FFF_FFFC, 1, 0, 33, "s_m7_2_unsigned");
    wait_done(0);
    start_op(0, 1, 7, 32'hFFFF_FFFE, 1, 0, 7, 0, 33, "s_7_m2_unsigned");
    wait_done(0);
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 0, 33, "s_min_m1_unsigned");
    wait_done(0);
`endif
    start_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0, 33, "u_max_max");
    wait_done(0);

    // Divide by zero in both modes, then a normal op clears the flag.
    start_op(0, 0, 5, 0, 1, 32'hFFFF_FFFF, 5, 1, 1, "dbz_u");
    wait_done(0);
    start_op(0, 1, 32'hFFFF_FFFB, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 1, "dbz_s");
    wait_done(0);
    start_op(0, 0, 9, 3, 1, 3, 0, 0, 33, "clear_dbz");
    wait_done(0);

    // A start while busy must not disturb the running operation.
    start_op(0, 0, 100, 7, 1, 14, 2, 0, 33, "ignore_start");
    repeat (9) tick();
    start32 = 1'b1; dvd32 = 50; dvs32 = 5;
    tick();
    start32 = 1'b0;
    check("ignore_start/result_held", q32, 3);
    wait_done(0);

    // Reset mid-operation aborts with no done pulse.
    start_op(0, 0, 1000, 3, 0, 0, 0, 0, 0, "reset_abort");
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("reset_abort/busy", busy32, 0);
    check("reset_abort/quotient", q32, 0);
    check("reset_abort/remainder", r32, 0);
    check("reset_abort/div_by_zero", dbz32, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (done32) seen = 1'b1;
      tick();
    end
    check("reset_abort/no_done", seen, 0);

    // WIDTH=8 instance, including a back-to-back start in the done cycle.
    start_op(1, 0, 255, 16, 1, 15, 15, 0, 9, "w8_255_16");
    wait_done(1);
    start_op(1, 0, 200, 7, 1, 28, 4, 0, 9, "w8_back_to_back");
    wait_done(1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
